// File: rtl/alu_vec_pkg.sv
// ============================================================================
//  Module      : alu_vec_pkg
//  Description : Shared definitions for the ALU vector sequencer: vector
//                layout, sequencer state encoding and ALU opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_vec_pkg;

  // Test vector layout, MSB first: {ZeroExp, F, A, B, YExp}
  localparam int VEC_W    = 100;
  localparam int DATA_W   = 32;
  localparam int F_W      = 3;
  localparam int YEXP_LSB = 0;
  localparam int B_LSB    = 32;
  localparam int A_LSB    = 64;
  localparam int F_LSB    = 96;
  localparam int ZEXP_BIT = 99;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [F_W-1:0] ALU_AND = 3'b000;
  localparam logic [F_W-1:0] ALU_OR  = 3'b001;
  localparam logic [F_W-1:0] ALU_ADD = 3'b010;
  localparam logic [F_W-1:0] ALU_SUB = 3'b110;
  localparam logic [F_W-1:0] ALU_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_vec_compare.sv
// ============================================================================
//  Module      : alu_vec_compare
//  Description : Unpacks a held test vector into ALU operands/expected
//                results and flags a mismatch against the ALU response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_vec_compare
  import alu_vec_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic [DATA_W-1:0] dut_y,
  input  logic              dut_zero,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [F_W-1:0]    op_f,
  output logic              mismatch
);

  logic [DATA_W-1:0] y_exp;
  logic              zero_exp;

  assign op_a     = vec[A_LSB +: DATA_W];
  assign op_b     = vec[B_LSB +: DATA_W];
  assign op_f     = vec[F_LSB +: F_W];
  assign y_exp    = vec[YEXP_LSB +: DATA_W];
  assign zero_exp = vec[ZEXP_BIT];

  assign mismatch = (dut_y != y_exp) | (dut_zero != zero_exp);

endmodule

`default_nettype wire

// File: rtl/alu_vector_sequencer.sv
// ============================================================================
//  Module      : alu_vector_sequencer
//  Description : Reads test vectors from a synchronous ROM, drives the ALU,
//                waits a settle time, compares results and reports
//                pass/error count/first failing index.
//                Optional: STOP_ON_ERROR_EN ends the run at the first mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_vector_sequencer
  import alu_vec_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W:0]   NumVectors,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [VEC_W-1:0]  MemData,
  output logic [DATA_W-1:0] DutA,
  output logic [DATA_W-1:0] DutB,
  output logic [F_W-1:0]    DutF,
  input  logic [DATA_W-1:0] DutY,
  input  logic              DutZero,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [ERR_W-1:0]  ErrCount,
  output logic [ADDR_W-1:0] FailIndex
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   fail_q, fail_d;
  logic                mismatch;
  logic                last_vec;

  alu_vec_compare u_compare (
    .vec      (vec_q),
    .dut_y    (DutY),
    .dut_zero (DutZero),
    .op_a     (DutA),
    .op_b     (DutB),
    .op_f     (DutF),
    .mismatch (mismatch)
  );

  // Compare in ADDR_W+1 bits so a full 2^ADDR_W run ends without wrapping index.
  assign last_vec = ((ADDR_W+1)'(index_q) + (ADDR_W+1)'(1)) == num_q;

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    num_d   = num_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          num_d   = NumVectors;
          err_d   = '0;
          fail_d  = '0;
          index_d = '0;
          state_d = (NumVectors == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // MemAddr already carries index; the ROM samples it on this edge.
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        vec_d   = MemData;
        cnt_d   = CNT_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          if (err_q == '0)            fail_d = index_q;
        end
`ifdef STOP_ON_ERROR_EN
        if (mismatch || last_vec) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
`else
        if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every reported result.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      num_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign MemAddr   = index_q;
  assign Busy      = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                     (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign Done      = (state_q == ST_DONE);
  assign Pass      = Done && (err_q == '0);
  assign ErrCount  = err_q;
  assign FailIndex = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_vector_sequencer.sv
// ============================================================================
//  Module      : tb_alu_vector_sequencer
//  Description : Self-checking bench for alu_vector_sequencer with a ROM
//                model, a reference ALU and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_vector_sequencer;
  import alu_vec_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int SETTLE  = 2;
  localparam int ERR_W   = 16;
  localparam int PER_VEC = 3 + SETTLE;

  logic              Clock = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic [ADDR_W:0]   NumVectors = '0;
  logic [ADDR_W-1:0] MemAddr;
  logic [VEC_W-1:0]  MemData;
  logic [31:0]       DutA, DutB, DutY;
  logic [2:0]        DutF;
  logic              DutZero;
  logic              Busy, Done, Pass;
  logic [ERR_W-1:0]  ErrCount;
  logic [ADDR_W-1:0] FailIndex;

  alu_vector_sequencer #(
    .ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE), .ERR_W(ERR_W)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .NumVectors(NumVectors),
    .MemAddr(MemAddr), .MemData(MemData), .DutA(DutA), .DutB(DutB),
    .DutF(DutF), .DutY(DutY), .DutZero(DutZero), .Busy(Busy), .Done(Done),
    .Pass(Pass), .ErrCount(ErrCount), .FailIndex(FailIndex)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Synchronous-read vector ROM
  logic [VEC_W-1:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge Clock) MemData <= rom[MemAddr];

  // Reference ALU, with a fault hook on the zero flag
  logic        force_zero_low = 1'b0;
  logic [31:0] alu_y;
  always_comb begin
    alu_y = 32'h0;
    case (DutF)
      ALU_AND: alu_y = DutA & DutB;
      ALU_OR:  alu_y = DutA | DutB;
      ALU_ADD: alu_y = DutA + DutB;
      ALU_SUB: alu_y = DutA - DutB;
      ALU_SLT: alu_y = ($signed(DutA) < $signed(DutB)) ? 32'h1 : 32'h0;
      default: alu_y = 32'h0;
    endcase
  end
  assign DutY    = alu_y;
  assign DutZero = force_zero_low ? 1'b0 : (alu_y == 32'h0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] mk(input logic z, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] y);
    return {z, f, a, b, y};
  endfunction

  typedef struct {
    bit pass;
    int err;
    int fail;
    int done_cyc;
  } exp_t;

  exp_t sb[$];

  // Monitor: each rising Done pops one expected run result
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge Clock);
      if (Done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done=1 expected no completion");
        end else begin
          e = sb.pop_front();
          chk("pass",       64'(Pass),      64'(e.pass));
          chk("err_count",  64'(ErrCount),  64'(e.err));
          chk("fail_index", 64'(FailIndex), 64'(e.fail));
          chk("done_cycle", 64'(cyc),       64'(e.done_cyc));
          chk("busy_at_done", 64'(Busy),    64'(0));
        end
      end
      done_prev = Done;
    end
  end

  // Issue one run, push its expected result, optionally pulse Start mid-run
  task automatic run(input int n, input bit ep, input int ee, input int ef,
                     input int nvec, input bit poke, output int max_addr);
    exp_t e;
    bit   got;
    int   k;
    @(posedge Clock); #1;
    Start = 1'b1;
    NumVectors = (ADDR_W+1)'(n);
    @(posedge Clock); #1;
    Start = 1'b0;
    e.pass = ep; e.err = ee; e.fail = ef; e.done_cyc = cyc + nvec * PER_VEC;
    sb.push_back(e);
    max_addr = 0;
    if (poke) begin
      repeat (3) @(posedge Clock);
      #1;
      chk("busy_mid_run", 64'(Busy), 64'(1));
      Start = 1'b1;
      NumVectors = (ADDR_W+1)'(1);
      @(posedge Clock); #1;
      Start = 1'b0;
    end
    got = 1'b0;
    k = 0;
    while (!got && k < 4000) begin
      @(negedge Clock);
      if (int'(MemAddr) > max_addr) max_addr = int'(MemAddr);
      if (Done) got = 1'b1;
      k++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got Done=0 expected Done=1 within 4000 cycles");
    end
  endtask

  task automatic load_four(input bit bad);
    rom[0] = mk(1'b0, ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    rom[1] = mk(1'b0, ALU_OR,  32'h000000F0, 32'h0000000F, bad ? 32'h000000FE : 32'h000000FF);
    rom[2] = mk(1'b0, ALU_SLT, 32'h00000003, 32'h00000007, 32'h00000001);
    rom[3] = mk(1'b1, ALU_ADD, 32'hFFFFFFFF, 32'h00000001, bad ? 32'h00000001 : 32'h00000000);
  endtask

  initial begin
    int ma;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;

    // Reset state
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_memaddr", 64'(MemAddr), 64'(0));
    chk("rst_dut_a",   64'(DutA),    64'(0));
    chk("rst_dut_b",   64'(DutB),    64'(0));
    chk("rst_dut_f",   64'(DutF),    64'(0));
    chk("rst_busy",    64'(Busy),    64'(0));
    chk("rst_done",    64'(Done),    64'(0));
    chk("rst_pass",    64'(Pass),    64'(0));
    chk("rst_err",     64'(ErrCount),64'(0));
    chk("rst_fail",    64'(FailIndex),64'(0));
    Reset_n = 1'b1;

    // Empty run straight from IDLE
    run(0, 1'b1, 0, 0, 0, 1'b0, ma);
    chk("n0_dut_a",   64'(DutA),    64'(0));
    chk("n0_dut_b",   64'(DutB),    64'(0));
    chk("n0_dut_f",   64'(DutF),    64'(0));
    chk("n0_memaddr", 64'(MemAddr), 64'(0));

    // Single ADD vector
    rom[0] = mk(1'b0, ALU_ADD, 32'h1, 32'h2, 32'h3);
    run(1, 1'b1, 0, 0, 1, 1'b0, ma);
    chk("add_dut_f", 64'(DutF), 64'(3'b010));
    chk("add_dut_a", 64'(DutA), 64'(1));
    chk("add_dut_b", 64'(DutB), 64'(2));

    // SUB producing zero, then with a broken zero flag
    rom[0] = mk(1'b1, ALU_SUB, 32'h5, 32'h5, 32'h0);
    run(1, 1'b1, 0, 0, 1, 1'b0, ma);
    force_zero_low = 1'b1;
    run(1, 1'b0, 1, 0, 1, 1'b0, ma);
    force_zero_low = 1'b0;

    // Four vectors, indices 1 and 3 carry wrong YExp
    load_four(1'b1);
`ifdef STOP_ON_ERROR_EN
    run(4, 1'b0, 1, 1, 2, 1'b0, ma);
    chk("stop_max_addr", 64'(ma), 64'(1));
    chk("stop_hold_f", 64'(DutF), 64'(ALU_OR));
    chk("stop_hold_a", 64'(DutA), 64'(32'h000000F0));
`else
    run(4, 1'b0, 2, 1, 4, 1'b0, ma);
    chk("all_max_addr", 64'(ma), 64'(3));
    chk("all_hold_f", 64'(DutF), 64'(ALU_ADD));
    chk("all_hold_a", 64'(DutA), 64'(32'hFFFFFFFF));
`endif

    // Restart from DONE with all-good vectors clears the error count
    load_four(1'b0);
    run(4, 1'b1, 0, 0, 4, 1'b0, ma);

    // Start pulsed while busy is ignored
    load_four(1'b1);
`ifdef STOP_ON_ERROR_EN
    run(4, 1'b0, 1, 1, 2, 1'b1, ma);
`else
    run(4, 1'b0, 2, 1, 4, 1'b1, ma);
`endif

    // Reset asserted while vector 1 is settling
    load_four(1'b0);
    @(posedge Clock); #1;
    Start = 1'b1;
    NumVectors = (ADDR_W+1)'(4);
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (7) @(posedge Clock);
    #1;
    chk("pre_rst_memaddr", 64'(MemAddr), 64'(1));
    chk("pre_rst_busy",    64'(Busy),    64'(1));
    chk("pre_rst_dut_a",   64'(DutA),    64'(32'h000000F0));
    #2;
    Reset_n = 1'b0;
    @(posedge Clock); #1;
    chk("mid_rst_memaddr", 64'(MemAddr), 64'(0));
    chk("mid_rst_busy",    64'(Busy),    64'(0));
    chk("mid_rst_done",    64'(Done),    64'(0));
    chk("mid_rst_dut_a",   64'(DutA),    64'(0));
    chk("mid_rst_dut_f",   64'(DutF),    64'(0));
    chk("mid_rst_err",     64'(ErrCount),64'(0));
    @(negedge Clock);
    Reset_n = 1'b1;
    run(4, 1'b1, 0, 0, 4, 1'b0, ma);

    repeat (5) @(posedge Clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
